// File: rtl/adder_accum_ctrl_pkg.sv
// Shared definitions for the adder accumulation sequencer: FSM state encoding
// and a constant-width helper for sizing the term counter.
package adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Ceiling log2, usable in constant expressions for counter sizing.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/adder_accum_ctrl_cla.sv
// Carry-lookahead adder of 2*DATA_WIDTH bits built from 4-bit lookahead groups
// whose group generate/propagate terms chain the carry between groups.
module carry_lookaheadadder_16bit #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [2*DATA_WIDTH-1:0] inData_A,
  input  logic [2*DATA_WIDTH-1:0] inData_B,
  input  logic                    cin,
  output logic [2*DATA_WIDTH-1:0] sum,
  output logic                    cout
);

  localparam int W      = 2 * DATA_WIDTH;
  localparam int GROUPS = W / 4;

  logic [W-1:0] gen;
  logic [W-1:0] prop;
  logic [W:0]   carry;

  assign gen  = inData_A & inData_B;
  assign prop = inData_A ^ inData_B;

  // Each group derives its internal carries in two logic levels from the
  // group's incoming carry, then hands a lookahead carry to the next group.
  always_comb begin : lookahead
    logic c0;
    logic groupGen;
    logic groupProp;
    int   b;
    carry = '0;
    c0    = cin;
    for (int k = 0; k < GROUPS; k++) begin
      b = 4 * k;
      carry[b]   = c0;
      carry[b+1] = gen[b] | (prop[b] & c0);
      carry[b+2] = gen[b+1] | (prop[b+1] & gen[b]) | (prop[b+1] & prop[b] & c0);
      carry[b+3] = gen[b+2] | (prop[b+2] & gen[b+1]) | (prop[b+2] & prop[b+1] & gen[b])
                 | (prop[b+2] & prop[b+1] & prop[b] & c0);
      groupGen   = gen[b+3] | (prop[b+3] & gen[b+2]) | (prop[b+3] & prop[b+2] & gen[b+1])
                 | (prop[b+3] & prop[b+2] & prop[b+1] & gen[b]);
      groupProp  = &prop[b +: 4];
      c0         = groupGen | (groupProp & c0);
    end
    carry[W] = c0;
  end

  assign sum  = prop ^ carry[W-1:0];
  assign cout = carry[W];

endmodule

// File: rtl/adder_accum_ctrl.sv
// Sequencer that accumulates NUM_TERMS terms through one shared carry-lookahead
// adder and hands the truncated sum plus a sticky overflow flag to a consumer.
module adder_accum_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_TERMS  = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic [2*DATA_WIDTH-1:0] inData,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [2*DATA_WIDTH-1:0] outData,
  output logic                    overflow,
  output logic                    busy
);

  localparam int              CNT_W    = clog2(NUM_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

  state_t                  state;
  state_t                  nextState;
  logic [2*DATA_WIDTH-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    ovf;
  logic                    accept;
  logic                    clearAcc;
  logic [2*DATA_WIDTH-1:0] sum;
  logic                    cout;

  carry_lookaheadadder_16bit #(.DATA_WIDTH(DATA_WIDTH)) adder (
    .inData_A (acc),
    .inData_B (inData),
    .cin      (1'b0),
    .sum      (sum),
    .cout     (cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Handshake outputs depend only on state, so no input-to-ready/valid paths exist.
  always_comb begin
    nextState = state;
    inReady   = 1'b0;
    outValid  = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    clearAcc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          clearAcc  = 1'b1;
          nextState = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        inReady = 1'b1;
        busy    = 1'b1;
        accept  = inValid;
        if (inValid && (cnt == LAST_CNT)) begin
          nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        outValid = 1'b1;
        busy     = 1'b1;
        if (outReady) begin
          nextState = ST_IDLE;
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clearAcc) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= sum;
      cnt <= cnt + CNT_W'(1);
      ovf <= ovf | cout;
    end
  end

  // Result registers are retained after hand-off but masked until the next DONE.
  assign outData  = outValid ? acc : '0;
  assign overflow = outValid & ovf;

endmodule

// File: tb/tb_adder_accum_ctrl.sv
// Directed self-checking bench for adder_accum_ctrl: a default 10-term instance
// and a single-term instance share the clock and reset.
module tb_adder_accum_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        inValid;
  logic        inReady;
  logic [15:0] inData;
  logic        outValid;
  logic        outReady;
  logic [15:0] outData;
  logic        overflow;
  logic        busy;

  logic        oneStart;
  logic        oneInValid;
  logic        oneInReady;
  logic [15:0] oneInData;
  logic        oneOutValid;
  logic        oneOutReady;
  logic [15:0] oneOutData;
  logic        oneOverflow;
  logic        oneBusy;

  int checkCount;
  int errorCount;

  adder_accum_ctrl #(.DATA_WIDTH(8), .NUM_TERMS(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .inValid  (inValid),
    .inReady  (inReady),
    .inData   (inData),
    .outValid (outValid),
    .outReady (outReady),
    .outData  (outData),
    .overflow (overflow),
    .busy     (busy)
  );

  adder_accum_ctrl #(.DATA_WIDTH(8), .NUM_TERMS(1)) dutOne (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (oneStart),
    .inValid  (oneInValid),
    .inReady  (oneInReady),
    .inData   (oneInData),
    .outValid (oneOutValid),
    .outReady (oneOutReady),
    .outData  (oneOutData),
    .overflow (oneOverflow),
    .busy     (oneBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feeds count copies of term, idling gap cycles between terms with junk data.
  task automatic applyStimulus(input logic [15:0] term, input int count, input int gap);
    for (int i = 0; i < count; i++) begin
      inValid = 1'b1;
      inData  = term;
      if (i == 0) checkOutput("inReadyFirst", 32'(inReady), 32'd1);
      if (i == count - 1) checkOutput("noValidBeforeLast", 32'(outValid), 32'd0);
      step();
      inValid = 1'b0;
      inData  = 16'hFFFF;
      if (i < count - 1) begin
        for (int j = 0; j < gap; j++) step();
      end
    end
  endtask

  task automatic startRun();
    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput("busyAfterStart", 32'(busy), 32'd1);
  endtask

  initial begin
    checkCount  = 0;
    errorCount  = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    inValid     = 1'b0;
    inData      = 16'h0000;
    outReady    = 1'b0;
    oneStart    = 1'b0;
    oneInValid  = 1'b0;
    oneInData   = 16'h0000;
    oneOutReady = 1'b0;

    step();
    step();
    checkOutput("rstOutValid", 32'(outValid), 32'd0);
    checkOutput("rstInReady", 32'(inReady), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstOutData", 32'(outData), 32'd0);
    checkOutput("rstOverflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    // IDLE ignores inValid without a start
    inValid = 1'b1;
    inData  = 16'h0055;
    step();
    inValid = 1'b0;
    checkOutput("idleIgnoresValid", 32'(busy), 32'd0);

    // Back-to-back ones with the consumer always ready
    outReady = 1'b1;
    startRun();
    applyStimulus(16'h0001, 10, 0);
    checkOutput("onesValid", 32'(outValid), 32'd1);
    checkOutput("onesData", 32'(outData), 32'h000A);
    checkOutput("onesOvf", 32'(overflow), 32'd0);
    step();
    checkOutput("onesExitValid", 32'(outValid), 32'd0);
    checkOutput("onesExitData", 32'(outData), 32'd0);

    // 255*255 terms wrap and set the sticky overflow
    startRun();
    applyStimulus(16'hFE01, 10, 0);
    checkOutput("sqValid", 32'(outValid), 32'd1);
    checkOutput("sqData", 32'(outData), 32'h0000_EC0A);
    checkOutput("sqOvf", 32'(overflow), 32'd1);
    step();
    checkOutput("sqExitOvf", 32'(overflow), 32'd0);
    checkOutput("sqExitBusy", 32'(busy), 32'd0);

    // Input gaps and output backpressure
    outReady = 1'b0;
    startRun();
    applyStimulus(16'h1234, 10, 2);
    checkOutput("gapValid", 32'(outValid), 32'd1);
    checkOutput("gapData", 32'(outData), 32'h0000_B608);
    checkOutput("gapOvf", 32'(overflow), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      checkOutput("holdValid", 32'(outValid), 32'd1);
      checkOutput("holdData", 32'(outData), 32'h0000_B608);
    end
    outReady = 1'b1;
    step();
    outReady = 1'b0;
    checkOutput("releaseValid", 32'(outValid), 32'd0);
    checkOutput("releaseBusy", 32'(busy), 32'd0);

    // start pulses in ACCUM, in DONE and on the DONE exit cycle are ignored
    startRun();
    applyStimulus(16'h0003, 3, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput("accumStartBusy", 32'(busy), 32'd1);
    checkOutput("accumStartReady", 32'(inReady), 32'd1);
    applyStimulus(16'h0003, 7, 0);
    checkOutput("startSumValid", 32'(outValid), 32'd1);
    checkOutput("startSumData", 32'(outData), 32'h0000_001E);
    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput("doneStartValid", 32'(outValid), 32'd1);
    checkOutput("doneStartData", 32'(outData), 32'h0000_001E);
    start    = 1'b1;
    outReady = 1'b1;
    step();
    start    = 1'b0;
    outReady = 1'b0;
    checkOutput("exitStartBusy", 32'(busy), 32'd0);
    step();
    checkOutput("exitStartStillIdle", 32'(busy), 32'd0);
    checkOutput("exitStartNoReady", 32'(inReady), 32'd0);

    // Reset mid-accumulation discards the partial sum and overflow
    startRun();
    applyStimulus(16'hFE01, 6, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstReady", 32'(inReady), 32'd0);
    checkOutput("midRstValid", 32'(outValid), 32'd0);
    checkOutput("midRstData", 32'(outData), 32'd0);
    outReady = 1'b1;
    startRun();
    applyStimulus(16'h0002, 10, 0);
    checkOutput("postRstValid", 32'(outValid), 32'd1);
    checkOutput("postRstData", 32'(outData), 32'h0000_0014);
    checkOutput("postRstOvf", 32'(overflow), 32'd0);
    step();
    outReady = 1'b0;

    // Single-term instance goes straight to DONE after one accept
    oneStart = 1'b1;
    step();
    oneStart = 1'b0;
    checkOutput("oneReady", 32'(oneInReady), 32'd1);
    oneInValid = 1'b1;
    oneInData  = 16'hBEEF;
    checkOutput("oneNoValidYet", 32'(oneOutValid), 32'd0);
    step();
    oneInValid = 1'b0;
    oneInData  = 16'h0000;
    checkOutput("oneValid", 32'(oneOutValid), 32'd1);
    checkOutput("oneData", 32'(oneOutData), 32'h0000_BEEF);
    checkOutput("oneOvf", 32'(oneOverflow), 32'd0);
    checkOutput("oneBusy", 32'(oneBusy), 32'd1);
    oneOutReady = 1'b1;
    step();
    oneOutReady = 1'b0;
    checkOutput("oneExitValid", 32'(oneOutValid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/adder_accum_ctrl.md
Name: adder_accum_ctrl

Overview:
Sequencer that shares one 16-bit carry-lookahead adder (carry_lookaheadadder_16bit) to accumulate a fixed-length stream of 2*DATA_WIDTH-bit terms, e.g. the NUM_TERMS partial products of one dot-product row in the 10x10 8-bit multiplier array.
- A start pulse clears the accumulator; the block then accepts exactly NUM_TERMS terms over a valid/ready handshake.
- It then presents the truncated sum plus a sticky overflow flag over a second valid/ready handshake.

Parameters:
DATA_WIDTH, 8, operand width; accumulator, terms and result are 2*DATA_WIDTH bits (the adder instance is fixed at 16 bits, so only 8 is legal).
NUM_TERMS, 10, terms per accumulation; legal range 1..255.

Ports:
clk  in  1  rising-edge clock, sole clock domain
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle request to begin accumulation; honoured only in IDLE
inValid  in  1  inData holds a valid term
inReady  out  1  block accepts a term this cycle
inData  in  2*DATA_WIDTH  term to add
outValid  out  1  result available
outReady  in  1  consumer accepts result
outData  out  2*DATA_WIDTH  accumulated sum, modulo 2^(2*DATA_WIDTH)
overflow  out  1  at least one adder carry-out occurred during this accumulation
busy  out  1  high in ACCUM and DONE

Behaviour:
- Reset (rst_n low at a clock edge), including mid-operation:
  - state=IDLE, acc=0, cnt=0, ovf=0.
  - Outputs: inReady=0, outValid=0, outData=0, overflow=0, busy=0.
  - Any partial accumulation is discarded.
- States: IDLE, ACCUM, DONE, encoded in 2 bits.
- IDLE:
  - inReady=0, outValid=0.
  - start=1 -> acc<=0, cnt<=0, ovf<=0, next state ACCUM.
  - inValid is ignored.
- ACCUM:
  - inReady=1 (combinational from state only).
  - Accept occurs when inValid&&inReady. On accept: acc<=sum, ovf<=ovf|cout, cnt<=cnt+1.
  - If cnt==NUM_TERMS-1 on accept -> next state DONE.
  - Cycles with inValid=0 hold all state. Gaps of any length are legal.
- Adder hookup: inData_A=acc, inData_B=inData, cin=0; the sum and cout outputs are used only on accept cycles.
- DONE:
  - outValid=1, outData=acc, overflow=ovf, inReady=0.
  - outValid and outData hold stable while outReady=0.
  - outReady=1 -> next state IDLE. acc and ovf are retained but not presented once outValid=0.
- outData and overflow are driven from registers and read 0 whenever outValid=0.
- Latency: outValid rises the cycle after the final term is accepted. Minimum start-to-outValid is NUM_TERMS+1 cycles.
- start while in ACCUM or DONE: ignored, with no effect on acc, cnt or ovf.
- start in the same cycle DONE is exited: ignored. A new start is needed once in IDLE.
- Counter width is clog2(NUM_TERMS+1). cnt never wraps, because the transition to DONE occurs at NUM_TERMS-1.
- NUM_TERMS=1: a single accept goes straight to DONE with acc=inData and ovf=0.
- No combinational path from inValid to inReady, or from outReady to outValid.

Decomposition:
- Shared package adder_ctrl_pkg holds:
  - state localparams ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_DONE=2'd2;
  - a clog2 constant function for the counter width.
- One sub-module instance: the existing carry_lookaheadadder_16bit #(.DATA_WIDTH(DATA_WIDTH)), used as the only arithmetic.
- FSM, counter and registers stay in adder_accum_ctrl.

Test Plan:
- Default params: start, then 10 back-to-back terms of 16'h0001 with outReady=1 -> outValid exactly 1 cycle after the 10th accept; outData=16'h000A, overflow=0.
- 10 terms of 16'hFE01 (255*255) -> outData=16'hEC0A (650250 mod 65536), overflow=1.
- Backpressure:
  - inValid toggled 1-0-0-1 between terms -> same result as the gapless case.
  - outReady held 0 for 5 cycles in DONE -> outValid/outData stable; IDLE the cycle after outReady=1.
- start pulsed during ACCUM after 3 terms, and again while in DONE -> ignored; final sum still covers all 10 terms.
- rst_n=0 for one cycle after 6 terms -> all outputs 0 and IDLE next cycle. A new start plus 10 terms of 16'h0002 gives 16'h0014, with no residue from the aborted run.
- NUM_TERMS=1 build: start, then one term 16'hBEEF -> outData=16'hBEEF, overflow=0, outValid 1 cycle after the accept.
